// File: rtl/i_decode.sv
// Instruction decode stage: register file, control decoder,
// sign extender, load-use hazard detection and ID/EX register.
module i_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instruction,
  input  logic [31:0] IF_ID_npc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_writereg,
  input  logic [31:0] MEM_WB_writedata,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  ID_EX_wb,
  output logic [2:0]  ID_EX_m,
  output logic [3:0]  ID_EX_ex,
  output logic [31:0] ID_EX_npc,
  output logic [31:0] ID_EX_readdat1,
  output logic [31:0] ID_EX_readdat2,
  output logic [31:0] ID_EX_sign_ext,
  output logic [4:0]  ID_EX_instr_2016,
  output logic [4:0]  ID_EX_instr_1511
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] rf_q [32];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sext_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [1:0]  wb_d;
  logic [2:0]  m_d;
  logic [3:0]  ex_d;
  logic        wr_en;
  logic        hazard;
  logic        bubble;

  logic [1:0]  wb_q;
  logic [2:0]  m_q;
  logic [3:0]  ex_q;
  logic [31:0] npc_q;
  logic [31:0] rd1_q;
  logic [31:0] rd2_q;
  logic [31:0] sext_q;
  logic [4:0]  rt_q;
  logic [4:0]  rdf_q;

  assign opcode = IF_ID_instruction[31:26];
  assign rs     = IF_ID_instruction[25:21];
  assign rt     = IF_ID_instruction[20:16];
  assign rd     = IF_ID_instruction[15:11];
  assign sext_d = {{16{IF_ID_instruction[15]}},
                   IF_ID_instruction[15:0]};

  assign wr_en = MEM_WB_RegWrite &&
                 (MEM_WB_writereg != 5'd0);

  // Register file write port; r0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= 32'd0;
    end else if (wr_en) begin
      rf_q[MEM_WB_writereg] <= MEM_WB_writedata;
    end
  end

  // Read ports with same-cycle write-back bypass
  always_comb begin
    rd1_d = rf_q[rs];
    rd2_d = rf_q[rt];
    if (wr_en && (MEM_WB_writereg == rs))
      rd1_d = MEM_WB_writedata;
    if (wr_en && (MEM_WB_writereg == rt))
      rd2_d = MEM_WB_writedata;
    if (rs == 5'd0)
      rd1_d = 32'd0;
    if (rt == 5'd0)
      rd2_d = 32'd0;
  end

  // Main control decoder
  always_comb begin
    wb_d = 2'b00;
    m_d  = 3'b000;
    ex_d = 4'b0000;
    case (opcode)
      OP_RTYPE: begin
        ex_d = 4'b1100;
        wb_d = 2'b10;
      end
      OP_LW: begin
        ex_d = 4'b0001;
        m_d  = 3'b010;
        wb_d = 2'b11;
      end
      OP_SW: begin
        ex_d = 4'b0001;
        m_d  = 3'b001;
      end
      OP_BEQ: begin
        ex_d = 4'b0010;
        m_d  = 3'b100;
      end
      default: begin
        wb_d = 2'b00;
      end
    endcase
  end

  // Load-use hazard; a flush overrides the stall
  always_comb begin
    hazard = m_q[1] && (rt_q != 5'd0) &&
             ((rt_q == rs) || (rt_q == rt));
    stall  = hazard && !flush;
    bubble = flush || stall;
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q   <= '0;
      m_q    <= '0;
      ex_q   <= '0;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      sext_q <= '0;
      rt_q   <= '0;
      rdf_q  <= '0;
    end else begin
      wb_q   <= bubble ? 2'b00 : wb_d;
      m_q    <= bubble ? 3'b000 : m_d;
      ex_q   <= bubble ? 4'b0000 : ex_d;
      npc_q  <= IF_ID_npc;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      sext_q <= sext_d;
      rt_q   <= rt;
      rdf_q  <= rd;
    end
  end

  assign ID_EX_wb         = wb_q;
  assign ID_EX_m          = m_q;
  assign ID_EX_ex         = ex_q;
  assign ID_EX_npc        = npc_q;
  assign ID_EX_readdat1   = rd1_q;
  assign ID_EX_readdat2   = rd2_q;
  assign ID_EX_sign_ext   = sext_q;
  assign ID_EX_instr_2016 = rt_q;
  assign ID_EX_instr_1511 = rdf_q;

endmodule
